// File: rtl/alu_ops_pkg.sv
// Shared ALU operation codes, RISC-V major opcodes and the skid-buffer state
// used by the ALU control stage (and later by the ALU itself).
package alu_ops_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0011,
    ALU_PASSB   = 4'b0101,
    ALU_XOR     = 4'b0110,
    ALU_EQ      = 4'b1000,
    ALU_NE      = 4'b1001,
    ALU_LT      = 4'b1010,
    ALU_ILLEGAL = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct3/funct7 -> ALU operation decode; zero latency.
// No state, no backpressure: illegal is raised whenever no ALU mapping exists.
module alu_op_decode
  import alu_ops_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] op,
  output logic       illegal
);

  alu_op_t op_d;
  logic    unused_funct7;

  // Only funct7[5] (ADD/SUB select) matters for the ops handled here.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    op_d = ALU_ILLEGAL;
    unique case (opcode)
      OPC_RTYPE, OPC_IALU: begin
        unique case (funct3)
          3'b000: op_d = (opcode == OPC_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b111: op_d = ALU_AND;
          3'b110: op_d = ALU_OR;
          3'b100: op_d = ALU_XOR;
          3'b010: op_d = ALU_LT;
          default: op_d = ALU_ILLEGAL;
        endcase
      end
      OPC_LOAD, OPC_STORE: op_d = ALU_ADD;
      OPC_BRANCH: begin
        unique case (funct3)
          3'b000: op_d = ALU_EQ;
          3'b001: op_d = ALU_NE;
          3'b100: op_d = ALU_LT;
          default: op_d = ALU_ILLEGAL;
        endcase
      end
      OPC_LUI, OPC_JAL: op_d = ALU_PASSB;
      default: op_d = ALU_ILLEGAL;
    endcase
  end

  assign op      = op_d;
  assign illegal = (op_d == ALU_ILLEGAL);

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage with two-entry skid buffer; latency 1 cycle.
// Backpressure: in_ready is a flop, low only while both entries are occupied.
module alu_ctrl_stage
  import alu_ops_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 64,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     illegal,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic [CNT_WIDTH-1:0]     illegal_cnt
);

  buf_state_t state_q, state_d;
  logic       in_ready_q;

  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_illegal;

  logic [OPCODE_LENGTH-1:0] main_op_q,  skid_op_q;
  logic                     main_ill_q, skid_ill_q;
  logic [PAYLOAD_WIDTH-1:0] main_pay_q, skid_pay_q;
  logic [CNT_WIDTH-1:0]     cnt_q;

  logic accept;
  logic deliver;

  alu_op_decode u_dec (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid && out_ready;

  // in_ready is registered from the next state so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BUF_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: if (accept) state_d = BUF_ONE;
        BUF_ONE: begin
          if (accept && !deliver)      state_d = BUF_TWO;
          else if (!accept && deliver) state_d = BUF_EMPTY;
        end
        BUF_TWO: if (deliver) state_d = BUF_ONE;
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid   = (state_q != BUF_EMPTY);
    in_ready    = in_ready_q;
    Operation   = main_op_q;
    illegal     = main_ill_q;
    out_payload = main_pay_q;
    illegal_cnt = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_op_q  <= '0;
      main_ill_q <= 1'b0;
      main_pay_q <= '0;
      skid_op_q  <= '0;
      skid_ill_q <= 1'b0;
      skid_pay_q <= '0;
    end else if (!flush) begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            main_op_q  <= dec_op;
            main_ill_q <= dec_illegal;
            main_pay_q <= in_payload;
          end
        end
        BUF_ONE: begin
          if (accept && deliver) begin
            main_op_q  <= dec_op;
            main_ill_q <= dec_illegal;
            main_pay_q <= in_payload;
          end else if (accept) begin
            skid_op_q  <= dec_op;
            skid_ill_q <= dec_illegal;
            skid_pay_q <= in_payload;
          end
        end
        BUF_TWO: begin
          if (deliver) begin
            main_op_q  <= skid_op_q;
            main_ill_q <= skid_ill_q;
            main_pay_q <= skid_pay_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Entries killed by a same-cycle flush never reach the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept && !flush && dec_illegal && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Pipelined ALU-control stage: decodes RISC-V instruction fields (opcode, funct3, funct7) into the 4-bit `Operation` code consumed by `alu`. It registers the code together with a pass-through operand payload behind a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`. It sits between instruction decode and the ALU input register and also counts illegal ALU encodings.

## Interface
- `PAYLOAD_WIDTH`, 64: width of the opaque payload carried alongside the decoded op (e.g. SrcA/SrcB).
- `OPCODE_LENGTH`, 4: width of `Operation`.
- `CNT_WIDTH`, 8: width of the illegal-encoding counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous pipeline kill.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept; registered.
- `opcode`  in  7  instr[6:0].
- `funct3`  in  3  instr[14:12].
- `funct7`  in  7  instr[31:25].
- `in_payload`  in  PAYLOAD_WIDTH  carried unchanged.
- `out_valid`  out  1  `Operation`/`out_payload` valid.
- `out_ready`  in  1  ALU side accepts.
- `Operation`  out  OPCODE_LENGTH  decoded ALU op.
- `illegal`  out  1  entry at head had no legal ALU mapping.
- `out_payload`  out  PAYLOAD_WIDTH  payload of head entry.
- `illegal_cnt`  out  CNT_WIDTH  saturating count of accepted illegal encodings.

## Operation
- Decode map:
  - R-type 0110011:
    - f3 000: ADD 0010 if funct7[5]=0, SUB 0011 if funct7[5]=1.
    - f3 111: AND 0000.
    - f3 110: OR 0001.
    - f3 100: XOR 0110.
    - f3 010: LT 1010.
  - I-ALU 0010011 uses the same f3 map, always ADD for 000.
  - Load 0000011 and store 0100011: ADD.
  - Branch 1100011:
    - f3 000: EQ 1000.
    - f3 001: NE 1001.
    - f3 100: LT 1010.
  - LUI 0110111 and JAL 1101111: PASS-B 0101.
  - Anything else: `Operation`=1111, `illegal`=1. The ALU yields 0 for this code.
- Transfer rules:
  - Accept on `in_valid && in_ready`.
  - Deliver on `out_valid && out_ready`.
- Buffer states:
  - EMPTY:
    - accept → ONE.
  - ONE (main full):
    - accept without deliver → TWO (entry goes to skid).
    - deliver without accept → EMPTY.
    - accept with deliver → ONE (new entry replaces main).
  - TWO (main + skid):
    - `in_ready`=0.
    - deliver → ONE (skid moves to main).
- Outputs always reflect the main register. `out_valid`=1 in ONE and TWO.
- Payload and decode results are held stable while `out_valid && !out_ready`.
- `illegal_cnt`:
  - Increments by 1 for each accepted illegal entry.
  - Saturates at all-ones with no wrap.
  - It is not cleared by `flush`.
- `flush`:
  - The next state is EMPTY and any same-cycle accept is discarded; a discarded accept is not counted.
  - Any same-cycle delivery still counts as delivered downstream.

## Timing
- Latency is 1 cycle: an entry accepted at edge N shows `out_valid` after edge N (cycle N+1) when the stage was EMPTY or draining.
- Throughput is 1 entry/cycle while `out_ready`=1.
- `in_ready` is a flop. It is 1 in EMPTY and ONE, and 0 in TWO.
- No combinational path from `out_ready` to `in_ready`.
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1, `Operation`=0000, `illegal`=0, `out_payload`=0, `illegal_cnt`=0.
- Reset mid-transfer drops all buffered entries. Reset dominates `flush`.
- The cycle after `flush` or `reset` has `in_ready`=1.

## Structure
- Package `alu_ops_pkg` holds:
  - `typedef enum logic [3:0] alu_op_t`: AND, OR, ADD, SUB, XOR, EQ, NE, LT, PASSB, ILLEGAL=1111.
  - RISC-V opcode localparams.
  - The buffer-state enum.
  - `alu` is to adopt this package later.
- Sub-module `alu_op_decode` is purely combinational: opcode/funct3/funct7 → `alu_op_t` plus illegal flag.
- The skid buffer and counter stay in `alu_ctrl_stage`.

## Test plan
- Reset, then R-type f3=000 f7=0100000 with payload 0xA5, `out_ready`=1:
  - next cycle `Operation`=0011, `out_payload`=0xA5, `illegal`=0.
- Back-to-back stream BEQ, BNE, LUI, LW with `out_ready`=1:
  - outputs 1000, 1001, 0101, 0010 on consecutive cycles.
  - `in_ready` stays 1.
- `out_ready`=0 while feeding 3 entries:
  - first two are held.
  - `in_ready` falls after the second accept.
  - raising `out_ready` drains them in order, then `in_ready`=1.
- Opcode 1110011 fed 300 times:
  - `illegal`=1, `Operation`=1111 each time.
  - `illegal_cnt` saturates at 255.
- State TWO, assert `flush` with `in_valid`=1 and an illegal encoding:
  - next cycle `out_valid`=0, `in_ready`=1, `illegal_cnt` unchanged.
- `reset` asserted while state is ONE:
  - all outputs return to their reset values on the next edge.
